// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 W[t] schedule generator; define SHA256_MSG_SCHED_ABORT_EN to add an abort input
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SHA256_MSG_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         start,
    input  logic [511:0] blk_in,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_idx,
    output logic         w_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_nx;
    logic [31:0] win [16];
    logic [31:0] w_new;
    logic [5:0]  t;
    logic        abt, last, xfer;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

`ifdef SHA256_MSG_SCHED_ABORT_EN
    assign abt = abort && state == RUN;
`else
    assign abt = 1'b0;
`endif
    assign last  = t == 6'(ROUNDS - 1);
    assign xfer  = state == RUN && w_ready && !abt;
    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clk)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? RUN : IDLE)
                                   : ((abt || (xfer && last)) ? IDLE : RUN);
    end

    always_comb begin
        w_valid = state == RUN;
        busy    = state == RUN;
        w_out   = win[0];
        w_idx   = t;
    end

    // window and index only move on load or on a non-final transfer, so they hold during stalls and after done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t    <= '0;
            done <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            done <= xfer && last;
            if (state == IDLE && start) begin
                t <= '0;
                for (int i = 0; i < 16; i++) win[i] <= blk_in[511 - 32*i -: 32];
            end else if (xfer && !last) begin
                t <= t + 6'd1;
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_new;
            end
        end
    end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: scoreboard bench comparing the schedule stream against a software model
module tb_sha256_msg_sched;
    logic         clk = 0, rst_n = 0, start = 0, w_ready = 0;
    logic [511:0] blk_in = '0;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_valid, busy, done;
`ifdef SHA256_MSG_SCHED_ABORT_EN
    logic         abort = 0;
`endif
    int           n_chk = 0, n_pass = 0;
    logic [37:0]  sb [$];
    logic [31:0]  got_w [64];

    always #5 clk = ~clk;

    sha256_msg_sched dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SHA256_MSG_SCHED_ABORT_EN
        .abort(abort),
`endif
        .start(start), .blk_in(blk_in), .w_ready(w_ready),
        .w_out(w_out), .w_idx(w_idx), .w_valid(w_valid), .busy(busy), .done(done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic push_block(input logic [511:0] b);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 64; i++) sb.push_back({6'(i), w[i]});
    endtask

    // called at a negedge; returns at the negedge where done (or the cut) has been observed
    task automatic run_block(input logic [511:0] b, input int rdy_pct, input int cut_at, input bit do_abort);
        logic [31:0] hold_w = '0;
        logic [5:0]  hold_i = '0;
        logic [37:0] e;
        bit          stalled = 0, fin = 0;
        int          cyc = 0;
        blk_in = b;
        start  = 1;
        push_block(b);
        @(negedge clk);
        start = 0;
        chk("lat_valid", 64'(w_valid), 64'd1);
        chk("lat_idx", 64'(w_idx), 64'd0);
        chk("done_pulse", 64'(done), 64'd0);
        while (!fin && cyc < 2000) begin
            cyc++;
            if (stalled) begin
                chk("stall_w", 64'(w_out), 64'(hold_w));
                chk("stall_i", 64'(w_idx), 64'(hold_i));
            end
            chk("run_valid", 64'(w_valid), 64'd1);
            chk("run_busy", 64'(busy), 64'd1);
            chk("no_done", 64'(done), 64'd0);
            if (cut_at >= 0 && int'(w_idx) == cut_at) begin
                if (do_abort) begin
`ifdef SHA256_MSG_SCHED_ABORT_EN
                    abort   = 1;
                    w_ready = 1;
                    @(negedge clk);
                    abort = 0;
                    chk("abort_valid", 64'(w_valid), 64'd0);
                    chk("abort_busy", 64'(busy), 64'd0);
                    @(negedge clk);
                    chk("abort_done", 64'(done), 64'd0);
`endif
                end else begin
                    rst_n   = 0;
                    start   = 1;
                    w_ready = 1;
                    repeat (2) begin
                        @(negedge clk);
                        chk("rst_out", {w_out, 26'd0, w_idx}, 64'd0);
                        chk("rst_ctl", {61'd0, w_valid, busy, done}, 64'd0);
                    end
                    rst_n = 1;
                    start = 0;
                    @(negedge clk);
                    chk("rst_idle", {62'd0, busy, done}, 64'd0);
                end
                sb.delete();
                fin = 1;
            end else begin
                w_ready = ($urandom_range(99) < rdy_pct);
                start   = (cyc == 3);
                stalled = w_valid && !w_ready;
                hold_w  = w_out;
                hold_i  = w_idx;
                if (w_valid && w_ready) begin
                    if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
                    else begin
                        e = sb.pop_front();
                        chk("word", 64'(w_out), 64'(e[31:0]));
                        chk("idx", 64'(w_idx), 64'(e[37:32]));
                        got_w[w_idx] = w_out;
                        if (e[37:32] == 6'd63) begin
                            @(negedge clk);
                            start = 0;
                            chk("done", 64'(done), 64'd1);
                            chk("end_valid", 64'(w_valid), 64'd0);
                            chk("end_busy", 64'(busy), 64'd0);
                            fin = 1;
                        end
                    end
                end
                if (!fin) @(negedge clk);
            end
        end
        if (!fin) chk("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [511:0] b27, b28, abc;
        b27 = 512'd1 << 32;
        b28 = 512'd1 << 448;
        abc = {32'h61626380, 448'd0, 32'h00000018};
        start = 1;
        repeat (3) @(negedge clk);
        chk("reset_out", {w_out, 26'd0, w_idx}, 64'd0);
        chk("reset_ctl", {61'd0, w_valid, busy, done}, 64'd0);
        rst_n = 1;
        start = 0;
        @(negedge clk);
        run_block(b27, 100, -1, 0);
        chk("w16_b27", 64'(got_w[16]), 64'h0000a000);
        run_block(b28, 100, -1, 0);
        chk("w16_b28", 64'(got_w[16]), 64'h02004000);
        chk("w17_b28", 64'(got_w[17]), 64'h00000001);
        run_block(abc, 100, -1, 0);
        chk("w16_abc", 64'(got_w[16]), 64'h61626380);
        chk("w17_abc", 64'(got_w[17]), 64'h000f0000);
        @(negedge clk);
        chk("idle_ctl", {61'd0, w_valid, busy, done}, 64'd0);
        run_block(abc, 50, -1, 0);
        @(negedge clk);
        run_block(abc, 70, 20, 0);
        run_block(abc, 100, -1, 0);
`ifdef SHA256_MSG_SCHED_ABORT_EN
        @(negedge clk);
        run_block(abc, 80, 30, 1);
        run_block(abc, 100, -1, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
